// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the memory stage and the data memory LSU.
// Request side is valid/ready; the response is a single-cycle pulse with no backpressure.
`timescale 1ns/1ps
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32I data memory with load/store unit (B/H/W, sign/zero extend, fault flags).
// Latency: response pulse LATENCY cycles after acceptance; one request outstanding.
// Backpressure: req_ready drops while a response is pending, except in the response cycle itself.
`timescale 1ns/1ps
module data_mem_lsu #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_lsu_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem [DEPTH];

    logic        ready;
    logic        accept;
    logic        rsp_now;
    logic        rsp_next;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          err_misalign;
    logic          err_range;
    logic          err_funct;
    logic          acc_err;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd;
    rsp_t          acc_rsp;
    rsp_t          pend_q;
    rsp_t          rsp_q;

    // ready is purely a function of registered state, never of req_valid
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = (state_q == IDLE) || (cnt_q == 3'd0);
        rsp_now  = (state_q == BUSY) && (cnt_q == 3'd0);
        accept   = bus.req_valid && ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 3'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (accept) begin
                    cnt_d = 3'(LATENCY - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register is loaded only on the edge that opens the response cycle
    assign rsp_next = (accept && (LATENCY == 1)) || ((state_q == BUSY) && (cnt_q == 3'd1));

    always_comb begin
        idx       = bus.req_addr[AW+1:2];
        lane      = bus.req_addr[1:0];
        word      = mem[idx];
        err_range = bus.req_addr[31:2] >= 30'(DEPTH);

        case (bus.req_funct3[1:0])
            2'b01:   err_misalign = bus.req_addr[0];
            2'b10:   err_misalign = |bus.req_addr[1:0];
            default: err_misalign = 1'b0;
        endcase

        if (bus.req_we) begin
            err_funct = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            err_funct = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
        end

        acc_err = err_misalign || err_range || err_funct;

        shifted = word >> {lane, 3'b000};
        case (bus.req_funct3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = shifted;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase

        case (bus.req_funct3[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = bus.req_wdata;
            end
        endcase

        acc_rsp.err   = acc_err;
        acc_rsp.rdata = (acc_err || bus.req_we) ? 32'd0 : load_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && bus.req_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                pend_q <= acc_rsp;
            end
            if (rsp_next) begin
                rsp_q <= (LATENCY == 1) ? acc_rsp : pend_q;
            end else begin
                rsp_q <= '0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_now;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu at LATENCY 1, 3 and 4 with a per-instance response scoreboard.
`timescale 1ns/1ps
module tb_data_mem_lsu;
    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        drv_valid [3];
    logic        drv_we    [3];
    logic [2:0]  drv_f3    [3];
    logic [31:0] drv_addr  [3];
    logic [31:0] drv_wdata [3];
    logic [31:0] drv_er    [3];
    logic        drv_ee    [3];

    logic        obs_ready [3];
    logic        obs_valid [3];
    logic        obs_err   [3];
    logic [31:0] obs_rdata [3];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit acc_flag [3];
    bit hs_on = 1'b0;
    int hs_j  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        data_mem_lsu_if bus ();
        data_mem_lsu #(
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.req_valid  = drv_valid[g];
        assign bus.req_we     = drv_we[g];
        assign bus.req_funct3 = drv_f3[g];
        assign bus.req_addr   = drv_addr[g];
        assign bus.req_wdata  = drv_wdata[g];
        assign obs_ready[g]   = bus.req_ready;
        assign obs_valid[g]   = bus.rsp_valid;
        assign obs_rdata[g]   = bus.rsp_rdata;
        assign obs_err[g]     = bus.rsp_err;
    end

    function automatic int lat(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(int k);
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(int k, exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(int k);
        exp_t e;
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // One clock: note acceptances, advance, then score every instance's response port
    task automatic tick();
        bit   acc [3];
        bit   exp_v;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            acc[k]      = rst_n && drv_valid[k] && obs_ready[k];
            acc_flag[k] = acc[k];
        end
        if (hs_on) begin
            chk1($sformatf("ready_pattern[%0d]", hs_j), obs_ready[1], (hs_j % 3) == 0);
            hs_j++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                e.rdata = drv_er[k];
                e.err   = drv_ee[k];
                e.cyc   = cyc + lat(k) - 1;
                qpush(k, e);
            end
        end
        for (int k = 0; k < 3; k++) begin
            exp_v = 1'b0;
            if (qsize(k) > 0) begin
                e = qfront(k);
                exp_v = (e.cyc == cyc);
            end
            chk1($sformatf("rsp_valid[%0d]@%0d", k, cyc), obs_valid[k], exp_v);
            if (exp_v) begin
                chk($sformatf("rsp_rdata[%0d]@%0d", k, cyc), obs_rdata[k], e.rdata);
                chk1($sformatf("rsp_err[%0d]@%0d", k, cyc), obs_err[k], e.err);
                qpop(k);
            end else begin
                chk($sformatf("idle_rdata[%0d]@%0d", k, cyc), obs_rdata[k], 32'd0);
                chk1($sformatf("idle_err[%0d]@%0d", k, cyc), obs_err[k], 1'b0);
            end
            while (qsize(k) > 0 && qfront(k).cyc < cyc) qpop(k);
        end
    endtask

    task automatic req(int k, logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                       logic [31:0] er, logic ee, bit keep);
        bit got = 1'b0;
        drv_valid[k] = 1'b1;
        drv_we[k]    = we;
        drv_f3[k]    = f3;
        drv_addr[k]  = addr;
        drv_wdata[k] = wd;
        drv_er[k]    = er;
        drv_ee[k]    = ee;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (acc_flag[k]) begin
                got = 1'b1;
                break;
            end
        end
        chk1($sformatf("accepted[%0d]@%h", k, addr), got, 1'b1);
        if (!keep) drv_valid[k] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (q0.size() + q1.size() + q2.size()) > 0; n++) tick();
        chk("drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            drv_valid[k] = 1'b0;
            drv_we[k]    = 1'b0;
            drv_f3[k]    = 3'b010;
            drv_addr[k]  = 32'd0;
            drv_wdata[k] = 32'd0;
            drv_er[k]    = 32'd0;
            drv_ee[k]    = 1'b0;
        end

        // Reset state
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("reset_ready[%0d]", k), obs_ready[k], 1'b1);
            chk1($sformatf("reset_valid[%0d]", k), obs_valid[k], 1'b0);
            chk($sformatf("reset_rdata[%0d]", k), obs_rdata[k], 32'd0);
            chk1($sformatf("reset_err[%0d]", k), obs_err[k], 1'b0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // SW then LW on every latency
        for (int k = 0; k < 3; k++) begin
            req(k, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
            req(k, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        end
        drain();

        // Sub-word stores and loads, back-to-back at LATENCY 1
        req(0, 1'b1, 3'b000, 32'h21, 32'h0000_0080, 32'd0, 1'b0, 1'b0);
        req(0, 1'b1, 3'b001, 32'h22, 32'h0000_7FFF, 32'd0, 1'b0, 1'b0);
        req(0, 1'b0, 3'b010, 32'h20, 32'd0, 32'h7FFF8000, 1'b0, 1'b0);
        req(0, 1'b0, 3'b000, 32'h21, 32'd0, 32'hFFFFFF80, 1'b0, 1'b0);
        req(0, 1'b0, 3'b100, 32'h21, 32'd0, 32'h00000080, 1'b0, 1'b0);
        req(0, 1'b0, 3'b001, 32'h22, 32'd0, 32'h00007FFF, 1'b0, 1'b0);
        req(0, 1'b0, 3'b001, 32'h20, 32'd0, 32'hFFFF8000, 1'b0, 1'b0);
        req(0, 1'b0, 3'b101, 32'h20, 32'd0, 32'h00008000, 1'b0, 1'b0);
        req(0, 1'b0, 3'b000, 32'h23, 32'd0, 32'h0000007F, 1'b0, 1'b0);
        req(0, 1'b0, 3'b100, 32'h13, 32'd0, 32'h000000DE, 1'b0, 1'b0);
        req(0, 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000DEAD, 1'b0, 1'b0);
        req(0, 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFFDEAD, 1'b0, 1'b0);
        drain();

        // Faults
        req(0, 1'b0, 3'b010, 32'h13, 32'd0, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b001, 32'h13, 32'd0, 32'd0, 1'b1, 1'b0);
        req(0, 1'b1, 3'b010, 32'h04, 32'h12345678, 32'd0, 1'b0, 1'b0);
        req(0, 1'b1, 3'b001, 32'h05, 32'h0000AAAA, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b010, 32'h04, 32'd0, 32'h12345678, 1'b0, 1'b0);
        req(0, 1'b1, 3'b100, 32'h04, 32'h000000FF, 32'd0, 1'b1, 1'b0);
        req(0, 1'b1, 3'b010, 32'h06, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b010, 32'h04, 32'd0, 32'h12345678, 1'b0, 1'b0);
        req(0, 1'b0, 3'b010, 32'(4 * DEPTH), 32'd0, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b010, 32'(4 * DEPTH - 4), 32'd0, 32'd0, 1'b0, 1'b0);
        req(0, 1'b1, 3'b010, 32'(4 * DEPTH), 32'hCAFEF00D, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b010, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        req(0, 1'b0, 3'b010, 32'hFFFFFFFC, 32'd0, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1'b0);
        req(0, 1'b0, 3'b110, 32'h10, 32'd0, 32'd0, 1'b1, 1'b0);
        drain();

        // Handshake at LATENCY 3 with req_valid held high across 4 loads
        for (int i = 0; i < 4; i++) begin
            req(1, 1'b1, 3'b010, 32'(32'h40 + 4 * i), 32'(32'h11111111 * (i + 1)), 32'd0, 1'b0, 1'b0);
        end
        drain();
        hs_on = 1'b1;
        hs_j  = 0;
        for (int i = 0; i < 4; i++) begin
            req(1, 1'b0, 3'b010, 32'(32'h40 + 4 * i), 32'd0, 32'(32'h11111111 * (i + 1)), 1'b0, 1'b1);
        end
        hs_on = 1'b0;
        drv_valid[1] = 1'b0;
        drain();

        // Reset two cycles after a LATENCY 4 load is accepted
        req(2, 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        #1;
        chk1("midreset_valid", obs_valid[2], 1'b0);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk1($sformatf("midreset_ready[%0d]", k), obs_ready[k], 1'b1);
        end
        rst_n = 1'b1;
        repeat (8) tick();
        req(2, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0);
        req(0, 1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0);
        req(1, 1'b0, 3'b010, 32'h40, 32'd0, 32'd0, 1'b0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, byte-addressable data memory with a load/store unit front end for the RV32 pipeline's memory stage. It supports RV32I byte, halfword and word loads and stores (sign- and zero-extending), and flags misaligned, out-of-range and illegal-width accesses. It uses a valid/ready request handshake and a configurable response latency. It replaces the word-only, zero-latency data memory and lets the memory stage stall on `req_ready`.

## Interface
- `DEPTH`, default 1024: memory size in 32-bit words; power of two, 16..65536.
- `LATENCY`, default 1: cycles from request acceptance to `rsp_valid`; 1..8.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data (rs2); low bytes are used for SB/SH.
- `rsp_valid` out 1: one-cycle response pulse; the consumer cannot backpressure.
- `rsp_rdata` out 32: load result, already extended; 0 for stores and errors.
- `rsp_err` out 1: access faulted; valid only with `rsp_valid`.

## Operation
- Acceptance: a request is accepted on a rising edge where `req_valid && req_ready`.
- Word index is `req_addr[log2(DEPTH)+1:2]`. Byte lane is `req_addr[1:0]`.
- Error checks, all evaluated at acceptance. Any hit sets `rsp_err` = 1, suppresses the write and forces `rsp_rdata` = 0.
  - Misaligned: H/HU/SH with `addr[0]` = 1, or W/SW with `addr[1:0]` ≠ 0.
  - Out of range: `req_addr[31:2] >= DEPTH`.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- Store
  - Commits at the acceptance edge using byte enables: SB writes lane `addr[1:0]`; SH writes lanes {1,0} or {3,2}; SW writes all 4 lanes.
  - Unselected bytes are untouched.
  - Lane data comes from `req_wdata[7:0]` (SB), `req_wdata[15:0]` (SH) or the full word (SW).
- Load
  - The addressed word is captured at the acceptance edge.
  - The selected byte or halfword is shifted to bit 0; B/H sign-extend, BU/HU zero-extend.
  - The result is held in a response register until the response cycle.
- FSM
  - IDLE: `req_ready` = 1. On acceptance, go to BUSY and load `cnt` = LATENCY−1.
  - BUSY, `cnt` ≠ 0: `req_ready` = 0; `cnt` decrements each cycle.
  - BUSY, `cnt` = 0: `rsp_valid` = 1 and `req_ready` = 1. If a new request is accepted, stay in BUSY with `cnt` = LATENCY−1; otherwise go to IDLE.
- At most one request is outstanding. A store still produces a response (`rsp_valid` pulse, `rdata` = 0).
- Read-after-write: a load accepted any cycle after a store to the same word sees the stored bytes.
- Reset, including mid-operation:
  - FSM → IDLE; the pending response is discarded.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - All memory words are cleared to 0.

## Timing
- Acceptance at edge T gives `rsp_valid` high during the cycle after edge T+LATENCY−1.
  - LATENCY=1: response in the cycle immediately after acceptance.
- Throughput is one request per LATENCY cycles. With LATENCY=1, back-to-back requests are accepted every cycle.
- `req_ready` is a registered-state function only. It never depends combinationally on `req_valid`.
- `rsp_rdata` and `rsp_err` are registered. They are stable for the whole `rsp_valid` cycle and are 0 when `rsp_valid` = 0.
- `req_*` inputs are sampled only at the acceptance edge; they may change freely afterwards.

## Test plan
- Reset then SW: with `rst_n` low, check `req_ready` = 1, `rsp_*` = 0. Then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `rsp_rdata` 0xDEADBEEF, `err` 0, `rsp_valid` exactly LATENCY cycles after each acceptance (run LATENCY=1 and 4).
- Sub-word stores: SB 0x80 to addr 0x21, then SH 0x7FFF to addr 0x22 over a zeroed word → LW 0x20 = 0x7FFF8000. LB 0x21 = 0xFFFFFF80; LBU 0x21 = 0x00000080; LH 0x22 = 0x00007FFF.
- Faults:
  - LW 0x13 → `err` 1, `rdata` 0.
  - SH 0x05 → `err` 1; a following LW 0x04 is unchanged.
  - LW at byte 4·DEPTH → `err` 1.
  - Load with funct3 011 → `err` 1.
- Handshake (LATENCY=3): hold `req_valid` high for 4 requests. Check `req_ready` pattern 1,0,0,1,0,0,…, exactly 4 `rsp_valid` pulses, and responses in request order.
- Reset mid-operation (LATENCY=4): assert `rst_n` low 2 cycles after a LW is accepted → no `rsp_valid` ever appears for it. After release, LW of a previously written address returns 0.
